stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter N_OUT, default 8: number of output channels; range 2..16.
REQ-002 Parameter DATA_W, default 8: data width in bits; range 1..64.
REQ-003 Parameter SEL_W, default $clog2(N_OUT): select width; derived, not overridden.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  input beat valid.
REQ-007 s_ready  output  1  input beat accepted when s_valid and s_ready are both high.
REQ-008 s_data  input  DATA_W  input payload.
REQ-009 s_sel  input  SEL_W  destination channel; sampled on the first beat of a packet only.
REQ-010 s_last  input  1  final beat of packet.
REQ-011 m_valid  output  N_OUT  per-channel valid.
REQ-012 m_ready  input  N_OUT  per-channel ready.
REQ-013 m_data  output  N_OUT*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-014 m_last  output  N_OUT  per-channel last.
REQ-015 err  output  1  one-cycle pulse when a packet's first beat carries s_sel >= N_OUT.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ROUTE and DROP.
REQ-017 IDLE: on an accepted beat, latch s_sel into cur_sel; go to ROUTE if s_sel < N_OUT, otherwise go to DROP.
REQ-018 IDLE, single-beat packet (s_last=1 on the first beat): stay in IDLE; the beat is still routed or dropped.
REQ-019 ROUTE and DROP: s_sel is ignored; return to IDLE on an accepted beat with s_last=1.
REQ-020 Each channel SHALL have a one-entry output register slot.
REQ-021 s_ready in IDLE SHALL be: (slot[s_sel] empty or m_ready[s_sel]) when s_sel < N_OUT; otherwise 1.
REQ-022 s_ready in ROUTE SHALL be: slot[cur_sel] empty or m_ready[cur_sel].
REQ-023 s_ready in DROP SHALL be 1; accepted beats are discarded.
REQ-024 s_ready SHALL NOT depend combinationally on s_valid.
REQ-025 Latency SHALL be one cycle: a beat accepted at edge t appears on m_* after edge t.
REQ-026 Throughput SHALL be one beat per cycle per channel when m_ready stays high.
REQ-027 Simultaneous drain and load of the same slot SHALL replace its contents with no bubble.
REQ-028 An m_valid beat SHALL hold m_data and m_last stable until m_ready is high.
REQ-029 Channels not selected SHALL hold their state; only the selected slot loads.
REQ-030 Packets SHALL never interleave: all beats of a packet go to one channel, in order.
REQ-031 err SHALL be asserted for exactly the cycle after the IDLE->DROP beat is accepted.

Reset
REQ-032 While rst is high, the FSM SHALL be in IDLE and cur_sel SHALL be 0.
REQ-033 While rst is high, every slot SHALL be empty, with m_valid=0, m_last=0, m_data=0 and err=0.
REQ-034 rst asserted mid-packet SHALL discard in-flight slot contents and the partial packet, with no further m_valid.

Configuration
REQ-035 Macro STREAM_DEMUX_DROP_CNT_EN defined: add output drop_cnt (16 bits), incremented once per dropped beat, saturating at 16'hFFFF, cleared by rst.
REQ-036 Macro STREAM_DEMUX_DROP_CNT_EN undefined: the drop_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Package stream_demux_pkg SHALL hold the FSM state typedef (IDLE/ROUTE/DROP) and localparam DROP_CNT_W=16.
REQ-038 Sub-module stream_demux_slot (one-entry valid/ready register, DATA_W+1 bits) SHALL be instantiated N_OUT times via generate.

Verification
REQ-039 Reset: hold rst 2 cycles with s_valid=1 -> m_valid=0, s_ready=0 in ROUTE is impossible (FSM is IDLE), err=0.
REQ-040 Three-beat packet, s_sel=3, data 0xA1/0xA2/0xA3, all m_ready=1 -> m_valid[3] is high on 3 consecutive cycles, data in order, m_last only on 0xA3.
REQ-041 Packet to ch 5 with m_ready[5]=0 after beat 1 -> s_ready=0; beat 2 is held until m_ready[5] rises; s_sel changes mid-packet have no effect.
REQ-042 s_sel=9, N_OUT=8, 2-beat packet -> err pulses once, no m_valid; drop_cnt=2 with STREAM_DEMUX_DROP_CNT_EN defined.
REQ-043 Back-to-back single-beat packets to ch 0,1,0,7 at full rate -> four outputs, one cycle apart, none lost.
REQ-044 rst asserted between beats 1 and 2 of a packet -> all m_valid=0 next cycle; the following packet routes by its own s_sel.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux packet router.
// The optional drop counter is enabled by defining STREAM_DEMUX_DROP_CNT_EN.
package stream_demux_pkg;

  localparam int DROP_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ROUTE = 2'd1;
  localparam state_t DROP  = 2'd2;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready output register; loads and drains in the same cycle without a bubble.
module stream_demux_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         room
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // The parent only asserts load when room is high, so a held beat is never overwritten.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign room      = !valid_q || out_ready;

endmodule

// File: rtl/stream_demux.sv
// Packet demultiplexer: routes each packet to the channel named on its first beat.
// Define STREAM_DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
//
// Handshake: a beat moves on any port exactly when its valid and ready are both high
// at a rising edge; s_ready never looks at s_valid, and a held m_* beat stays stable
// until its m_ready is seen high.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT  = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic                    err,
`ifdef STREAM_DEMUX_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]   drop_cnt,
`endif
  output state_t                  dbg_state
);

  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] act_sel;
  logic             sel_in_range;
  logic             route_en;
  logic             sel_room;
  logic             accept;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] slot_room;

  always_comb begin
    sel_in_range = ({1'b0, s_sel} < N_OUT_L);
    act_sel      = (state_q == IDLE) ? s_sel : cur_sel_q;
    // In ROUTE the latched channel is always in range, so only IDLE needs the range test.
    route_en     = (state_q == ROUTE) || ((state_q == IDLE) && sel_in_range);

    sel_room = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (act_sel == SEL_W'(k)) sel_room = slot_room[k];
    end

    s_ready = route_en ? sel_room : 1'b1;
    accept  = s_valid && s_ready;

    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept && route_en && (act_sel == SEL_W'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    err_d     = accept && (state_q == IDLE) && !sel_in_range;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_sel_d = s_sel;
          if (!s_last) state_d = sel_in_range ? ROUTE : DROP;
        end
      end
      ROUTE, DROP: begin
        if (accept && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      err_q     <= err_d;
    end
  end

  assign err       = err_q;
  assign dbg_state = state_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    logic [DATA_W:0] slot_out;

    stream_demux_slot #(.W(DATA_W + 1)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data ({s_last, s_data}),
      .out_ready (m_ready[k]),
      .out_valid (m_valid[k]),
      .out_data  (slot_out),
      .room      (slot_room[k])
    );

    assign m_last[k]                     = slot_out[DATA_W];
    assign m_data[k*DATA_W +: DATA_W]    = slot_out[DATA_W-1:0];
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !route_en && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: per-channel expected queues fed by packet-level routing rules,
// one negedge compare process, and literal checks on the captured output log.
module tb_stream_demux;
  import stream_demux_pkg::*;

  // N_OUT=9 gives a 4-bit select, so selects such as 9 and 15 are out of range.
  localparam int N_OUT  = 9;
  localparam int DATA_W = 8;
  localparam int SEL_W  = $clog2(N_OUT);

  logic                    clk;
  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data;
  logic [SEL_W-1:0]        s_sel;
  logic                    s_last;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_ready;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [N_OUT-1:0]        m_last;
  logic                    err;
  state_t                  dbg_state;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0]   drop_cnt;
`endif

  stream_demux #(.N_OUT(N_OUT), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sel     (s_sel),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .err       (err),
`ifdef STREAM_DEMUX_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int             ch;
    logic           last;
    logic [7:0]     data;
    int             cyc;
  } log_t;

  logic [DATA_W:0] exp_q[N_OUT][$];
  log_t            out_log[$];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              err_pulses = 0;
  int              exp_drop = 0;
  logic            exp_err = 1'b0;
  bit              chk_en = 1'b0;
  int              pkt_dest = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int q_total();
    int t = 0;
    for (int k = 0; k < N_OUT; k++) t += exp_q[k].size();
    return t;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N_OUT; k++) exp_q[k].delete();
    exp_err  = 1'b0;
    exp_drop = 0;
    pkt_dest = -1;
  endtask

  // Each channel holds at most one beat, so a non-empty queue means that beat must be on m_*.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N_OUT; k++) begin
        bit   ev;
        log_t e;
        ev = (exp_q[k].size() != 0);
        chk($sformatf("m_valid[%0d]", k), m_valid[k], ev);
        if (m_valid[k] && ev) begin
          chk($sformatf("m_beat[%0d]", k), {m_last[k], m_data[k*DATA_W +: DATA_W]}, exp_q[k][0]);
          if (m_ready[k]) begin
            e.ch   = k;
            e.last = m_last[k];
            e.data = m_data[k*DATA_W +: DATA_W];
            e.cyc  = cyc;
            out_log.push_back(e);
            void'(exp_q[k].pop_front());
          end
        end
      end
      chk("err", err, exp_err);
      if (err) err_pulses++;
      exp_err = 1'b0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, exp_drop);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [SEL_W-1:0] sel, input logic [7:0] d,
                           input logic last, input bit first);
    bit acc = 1'b0;
    int n = 0;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = d;
    s_last  = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      chk("beat_accept_timeout", 0, 1);
    end else begin
      if (first) begin
        pkt_dest = (int'(sel) < N_OUT) ? int'(sel) : -1;
        if (pkt_dest < 0) exp_err = 1'b1;
      end
      if (pkt_dest >= 0) exp_q[pkt_dest].push_back({last, d});
      else exp_drop++;
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int start;
  int pulses0;
  logic [7:0] dval;

  initial begin
    rst     = 1'b1;
    s_valid = 1'b1;
    s_sel   = 4'd3;
    s_data  = 8'h55;
    s_last  = 1'b0;
    m_ready = '0;

    // Reset held two cycles with s_valid high.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_err", err, 0);
      chk("rst_state_idle", dbg_state, 0);
      chk("rst_s_ready_idle_empty", s_ready, 1);
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = '1;
    idle(1);

    // Three-beat packet to channel 3 at full rate.
    start = out_log.size();
    send_beat(4'd3, 8'hA1, 1'b0, 1'b1);
    send_beat(4'd3, 8'hA2, 1'b0, 1'b0);
    send_beat(4'd3, 8'hA3, 1'b1, 1'b0);
    idle(3);
    chk("t1_count", out_log.size() - start, 3);
    if (out_log.size() - start == 3) begin
      for (int i = 0; i < 3; i++) begin
        dval = 8'hA1 + 8'(i);
        chk("t1_ch", out_log[start+i].ch, 3);
        chk("t1_data", out_log[start+i].data, dval);
        chk("t1_last", out_log[start+i].last, (i == 2));
        chk("t1_consecutive", out_log[start+i].cyc, out_log[start].cyc + i);
      end
    end

    // Channel 5 stalls after beat 1; select changes mid-packet are ignored.
    start = out_log.size();
    m_ready[5] = 1'b0;
    send_beat(4'd5, 8'hB1, 1'b0, 1'b1);
    s_valid = 1'b1;
    s_sel   = 4'd2;
    s_data  = 8'hB2;
    s_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_s_ready_stall", s_ready, 0);
      chk("t2_hold_valid", m_valid[5], 1);
      chk("t2_hold_data", m_data[5*DATA_W +: DATA_W], 8'hB1);
      @(posedge clk);
      #1;
    end
    m_ready[5] = 1'b1;
    send_beat(4'd2, 8'hB2, 1'b0, 1'b0);
    send_beat(4'd0, 8'hB3, 1'b1, 1'b0);
    idle(3);
    chk("t2_count", out_log.size() - start, 3);
    if (out_log.size() - start == 3) begin
      for (int i = 0; i < 3; i++) begin
        dval = 8'hB1 + 8'(i);
        chk("t2_ch", out_log[start+i].ch, 5);
        chk("t2_data", out_log[start+i].data, dval);
      end
    end

    // Out-of-range select: 2-beat packet dropped, then boundary selects 15 and 8.
    start   = out_log.size();
    pulses0 = err_pulses;
    send_beat(4'd9, 8'hC1, 1'b0, 1'b1);
    send_beat(4'd4, 8'hC2, 1'b1, 1'b0);
    idle(3);
    chk("t3_err_once", err_pulses - pulses0, 1);
    chk("t3_no_output", out_log.size() - start, 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 2);
`endif
    send_beat(4'd15, 8'hC3, 1'b1, 1'b1);
    send_beat(4'd8, 8'hC4, 1'b1, 1'b1);
    idle(3);
    chk("t3_err_twice", err_pulses - pulses0, 2);
    chk("t3_ch8_count", out_log.size() - start, 1);
    if (out_log.size() - start == 1) chk("t3_ch8", out_log[start].ch, 8);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("t3_drop_cnt3", drop_cnt, 3);
`endif

    // Back-to-back single-beat packets, including a same-channel pair.
    start = out_log.size();
    send_beat(4'd0, 8'hD0, 1'b1, 1'b1);
    send_beat(4'd1, 8'hD1, 1'b1, 1'b1);
    send_beat(4'd0, 8'hD2, 1'b1, 1'b1);
    send_beat(4'd7, 8'hD3, 1'b1, 1'b1);
    send_beat(4'd4, 8'hD4, 1'b1, 1'b1);
    send_beat(4'd4, 8'hD5, 1'b1, 1'b1);
    idle(3);
    chk("t4_count", out_log.size() - start, 6);
    if (out_log.size() - start == 6) begin
      int chs[6] = '{0, 1, 0, 7, 4, 4};
      for (int i = 0; i < 6; i++) begin
        dval = 8'hD0 + 8'(i);
        chk("t4_ch", out_log[start+i].ch, chs[i]);
        chk("t4_data", out_log[start+i].data, dval);
        chk("t4_consecutive", out_log[start+i].cyc, out_log[start].cyc + i);
      end
    end

    // Reset between beats 1 and 2 of a packet to channel 6.
    m_ready[6] = 1'b0;
    send_beat(4'd6, 8'hE1, 1'b0, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre_rst_valid", m_valid[6], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rst_valid", m_valid, 0);
    chk("t5_post_rst_state", dbg_state, 0);
    m_ready = '1;
    @(posedge clk);
    #1;
    start = out_log.size();
    send_beat(4'd2, 8'hE2, 1'b1, 1'b1);
    idle(3);
    chk("t5_count", out_log.size() - start, 1);
    if (out_log.size() - start == 1) begin
      chk("t5_ch", out_log[start].ch, 2);
      chk("t5_data", out_log[start].data, 8'hE2);
    end

    chk("final_queues_empty", q_total(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
